// File: rtl/pc8001m_pkg.sv
// pc8001m_pkg
//   Shared types and sizing helpers for the PC-8001 ROM loader.
//   ld_state_t  : loader FSM states.
//   ld_hold_w() : width of the reset-hold counter for a given hold length.
//   LD_HOLD_W   : that width at the default hold length of 64 clocks.
package pc8001m_pkg;

    typedef enum logic [1:0] {LD_IDLE, LD_DRAIN, LD_LOAD, LD_RELEASE} ld_state_t;

    localparam int HOLD_CYC_DFLT = 64;

    function automatic int ld_hold_w(input int hold_cyc);
        return $clog2(hold_cyc + 1);
    endfunction

    localparam int LD_HOLD_W = $clog2(HOLD_CYC_DFLT + 1);

endpackage

// File: rtl/pc8001m_rd_pipe.sv
// pc8001m_rd_pipe
//   Valid-bit shift register that tracks a memory read through the
//   MEM_LAT-clock memory latency.
//   clk, rst : clock, asynchronous active-high reset
//   start    : pulse on the clock the read address is on the memory bus
//   done     : high on the clock mem_rdata holds the read data
//   busy     : a read is still travelling through the pipe
module pc8001m_rd_pipe
    import pc8001m_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done,
    output logic busy
);

    logic [MEM_LAT-1:0] vld_pipe_q, vld_pipe_d;

    always_comb begin
        vld_pipe_d    = '0;
        vld_pipe_d[0] = start;
        for (int i = 1; i < MEM_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe_q <= '0;
        else     vld_pipe_q <= vld_pipe_d;
    end

    assign done = vld_pipe_q[MEM_LAT-1];
    assign busy = |vld_pipe_q;

endmodule

// File: rtl/pc8001m_rom_load_ctrl.sv
// pc8001m_rom_load_ctrl
//   Sequences hps_io ioctl ROM downloads (BIND88 slot) into the single
//   PC-8001 ROM/RAM write port, which it otherwise lends to the Z80 bus.
//   The CPU is held in reset for the download and HOLD_CYC clocks after it.
//   ioctl_*      : hps_io download stream in, ioctl_wait back-pressure out
//   cpu_*        : Z80 request/ack port, served only while the loader is idle
//   mem_*        : shared memory port (read data MEM_LAT clocks after address)
//   cpu_rst_hold : forces pc8001m reset
//   load_busy    : loader FSM not idle
//   load_ovf     : sticky, a byte beyond the ROM window was dropped
//   load_csum    : 16-bit sum of accepted bytes, only when the macro
//                  PC8001M_LOAD_CSUM_EN is defined
module pc8001m_rom_load_ctrl
    import pc8001m_pkg::*;
#(
    parameter int ROM_AW     = 15,
    parameter int LOAD_INDEX = 1,
    parameter int MEM_LAT    = 2,
    parameter int HOLD_CYC   = 64
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ROM_AW-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_rst_hold,
    output logic [ROM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
`ifdef PC8001M_LOAD_CSUM_EN
    output logic [15:0]       load_csum,
`endif
    output logic              load_busy,
    output logic              load_ovf
);

    localparam int         HOLD_W = ld_hold_w(HOLD_CYC);
    localparam logic [5:0] IDX    = 6'(LOAD_INDEX);

    ld_state_t         state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              buf_vld_q, buf_vld_d;
    logic [ROM_AW-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]        buf_data_q, buf_data_d;
    logic              wr_iss_q, wr_iss_d;
    logic              rd_iss_q, rd_iss_d;
    logic              ioctl_wait_q, ioctl_wait_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic              cpu_rst_hold_q, cpu_rst_hold_d;
    logic [ROM_AW-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              load_busy_q, load_busy_d;
    logic              load_ovf_q, load_ovf_d;

    logic dl_match, in_range, in_flight, rd_done, rd_busy;
    logic unused_idx;

    assign unused_idx = &{1'b0, ioctl_index[7:6]};
    assign dl_match   = ioctl_download && (ioctl_index[5:0] == IDX);
    assign in_range   = ioctl_addr < (25'd1 << ROM_AW);
    // cpu_ack_q is included so a requester still holding cpu_req on the
    // ack clock is not granted twice.
    assign in_flight  = wr_iss_q | rd_iss_q | rd_busy | cpu_ack_q;

    pc8001m_rd_pipe #(.MEM_LAT(MEM_LAT)) u_rd_pipe (
        .clk   (clk_sys),
        .rst   (reset),
        .start (rd_iss_q),
        .done  (rd_done),
        .busy  (rd_busy)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_vld_d   = 1'b0;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        wr_iss_d    = 1'b0;
        rd_iss_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        load_ovf_d  = load_ovf_q;
        cpu_ack_d   = wr_iss_q | rd_done;
        cpu_rdata_d = rd_done ? mem_rdata : cpu_rdata_q;

        // The skid buffer always empties into the memory port the clock
        // after capture, so a strobe on that same clock simply refills it.
        if (buf_vld_q) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = buf_addr_q;
            mem_wdata_d = buf_data_q;
        end

        case (state_q)
            LD_IDLE: begin
                if (dl_match) begin
                    state_d = LD_DRAIN;
                end else if (cpu_req && !in_flight) begin
                    mem_addr_d = cpu_addr;
                    if (cpu_we) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = cpu_wdata;
                        wr_iss_d    = 1'b1;
                    end else begin
                        rd_iss_d = 1'b1;
                    end
                end
            end
            LD_DRAIN: begin
                if (!in_flight) begin
                    state_d    = LD_LOAD;
                    load_ovf_d = 1'b0;
                end
            end
            LD_LOAD: begin
                if (ioctl_wr) begin
                    if (in_range) begin
                        buf_vld_d  = 1'b1;
                        buf_addr_d = ioctl_addr[ROM_AW-1:0];
                        buf_data_d = ioctl_dout;
                    end else begin
                        load_ovf_d = 1'b1;
                    end
                end else if (!ioctl_download && !buf_vld_q) begin
                    state_d = LD_RELEASE;
                    cnt_d   = HOLD_W'(HOLD_CYC);
                end
            end
            default: begin // LD_RELEASE
                if (dl_match) begin
                    state_d = LD_DRAIN;
                end else if (cnt_q <= HOLD_W'(1)) begin
                    // counter reaches zero on the same edge the hold drops
                    state_d = LD_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
        endcase

        cpu_rst_hold_d = (state_d != LD_IDLE);
        load_busy_d    = (state_d != LD_IDLE);
        ioctl_wait_d   = (state_d == LD_DRAIN);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q        <= LD_RELEASE;
            cnt_q          <= HOLD_W'(HOLD_CYC);
            buf_vld_q      <= 1'b0;
            buf_addr_q     <= '0;
            buf_data_q     <= '0;
            wr_iss_q       <= 1'b0;
            rd_iss_q       <= 1'b0;
            ioctl_wait_q   <= 1'b0;
            cpu_ack_q      <= 1'b0;
            cpu_rdata_q    <= '0;
            cpu_rst_hold_q <= 1'b1;
            mem_addr_q     <= '0;
            mem_we_q       <= 1'b0;
            mem_wdata_q    <= '0;
            load_busy_q    <= 1'b1;
            load_ovf_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            buf_vld_q      <= buf_vld_d;
            buf_addr_q     <= buf_addr_d;
            buf_data_q     <= buf_data_d;
            wr_iss_q       <= wr_iss_d;
            rd_iss_q       <= rd_iss_d;
            ioctl_wait_q   <= ioctl_wait_d;
            cpu_ack_q      <= cpu_ack_d;
            cpu_rdata_q    <= cpu_rdata_d;
            cpu_rst_hold_q <= cpu_rst_hold_d;
            mem_addr_q     <= mem_addr_d;
            mem_we_q       <= mem_we_d;
            mem_wdata_q    <= mem_wdata_d;
            load_busy_q    <= load_busy_d;
            load_ovf_q     <= load_ovf_d;
        end
    end

    // A strobe while wait is raised violates the hps_io handshake; the byte is dropped.
    always_ff @(posedge clk_sys) begin
        if (!reset && ioctl_wait_q) assert (!ioctl_wr);
    end

`ifdef PC8001M_LOAD_CSUM_EN
    logic [15:0] csum_q, csum_d;
    logic        csum_clr, csum_acc;

    assign csum_clr = dl_match && (state_q == LD_IDLE || state_q == LD_RELEASE);
    assign csum_acc = (state_q == LD_LOAD) && ioctl_wr && in_range;

    always_comb begin
        csum_d = csum_q;
        if (csum_clr)      csum_d = '0;
        else if (csum_acc) csum_d = csum_q + {8'h00, ioctl_dout};
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) csum_q <= '0;
        else       csum_q <= csum_d;
    end

    assign load_csum = csum_q;
`endif

    assign ioctl_wait   = ioctl_wait_q;
    assign cpu_ack      = cpu_ack_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign cpu_rst_hold = cpu_rst_hold_q;
    assign mem_addr     = mem_addr_q;
    assign mem_we       = mem_we_q;
    assign mem_wdata    = mem_wdata_q;
    assign load_busy    = load_busy_q;
    assign load_ovf     = load_ovf_q;

endmodule

// File: tb/tb_pc8001m_rom_load_ctrl.sv
`timescale 1ns/1ps
module tb_pc8001m_rom_load_ctrl;

    localparam int ROM_AW     = 15;
    localparam int LOAD_INDEX = 1;
    localparam int MEM_LAT    = 2;
    localparam int HOLD_CYC   = 64;

    logic              clk_sys = 1'b0;
    logic              reset = 1'b1;
    logic              ioctl_download = 1'b0;
    logic [7:0]        ioctl_index = 8'd0;
    logic              ioctl_wr = 1'b0;
    logic [24:0]       ioctl_addr = '0;
    logic [7:0]        ioctl_dout = '0;
    logic              ioctl_wait;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ROM_AW-1:0] cpu_addr = '0;
    logic [7:0]        cpu_wdata = '0;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;
    logic              cpu_rst_hold;
    logic [ROM_AW-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              load_busy;
    logic              load_ovf;
`ifdef PC8001M_LOAD_CSUM_EN
    logic [15:0]       load_csum;
    logic [15:0]       csum_m = '0;
`endif

    always #5 clk_sys = ~clk_sys;

    pc8001m_rom_load_ctrl #(
        .ROM_AW(ROM_AW), .LOAD_INDEX(LOAD_INDEX), .MEM_LAT(MEM_LAT), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rst_hold(cpu_rst_hold),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef PC8001M_LOAD_CSUM_EN
        .load_csum(load_csum),
`endif
        .load_busy(load_busy), .load_ovf(load_ovf)
    );

    // Memory model: synchronous write, read data MEM_LAT clocks after the address.
    logic [7:0]        mem    [0:(1<<ROM_AW)-1];
    logic [7:0]        shadow [0:(1<<ROM_AW)-1];
    logic [ROM_AW-1:0] a_pipe [MEM_LAT];

    initial begin
        for (int i = 0; i < (1 << ROM_AW); i++) begin
            mem[i]    = 8'h00;
            shadow[i] = 8'h00;
        end
        for (int i = 0; i < MEM_LAT; i++) a_pipe[i] = '0;
    end

    always @(posedge clk_sys) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        a_pipe[0] <= mem_addr;
        for (int i = 1; i < MEM_LAT; i++) a_pipe[i] <= a_pipe[i-1];
    end
    assign mem_rdata = mem[a_pipe[MEM_LAT-1]];

    // Scoreboard
    typedef struct packed { logic [ROM_AW-1:0] a; logic [7:0] d; } wr_t;
    typedef struct packed { logic rd; logic [7:0] d; } ack_t;
    wr_t  wq[$];
    ack_t aq[$];
    wr_t  mw;
    ack_t ma;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   we_cnt = 0;
    logic wait_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (!reset) begin
            if (mem_we) begin
                we_cnt++;
                if (wq.size() == 0) chk("we_spurious", 32'(wq.size()), 32'd1);
                else begin
                    mw = wq.pop_front();
                    chk("we_addr", 32'(mem_addr), 32'(mw.a));
                    chk("we_data", 32'(mem_wdata), 32'(mw.d));
                end
            end
            if (cpu_ack) begin
                if (aq.size() == 0) chk("ack_spurious", 32'(aq.size()), 32'd1);
                else begin
                    ma = aq.pop_front();
                    if (ma.rd) chk("rd_data", 32'(cpu_rdata), 32'(ma.d));
                end
            end
        end
    end

    task automatic cpu_op(input logic we, input logic [ROM_AW-1:0] a, input logic [7:0] d);
        int   k;
        ack_t e;
        wr_t  w;
        @(negedge clk_sys);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        e.rd = !we;
        e.d  = we ? 8'h00 : shadow[a];
        aq.push_back(e);
        if (we) begin
            w.a = a; w.d = d;
            wq.push_back(w);
            shadow[a] = d;
        end
        k = 0;
        do begin @(negedge clk_sys); k++; end while (!cpu_ack && k < 50);
        cpu_req = 1'b0;
        if (we) chk("cpu_wr_lat", k, 2);
        else    chk("cpu_rd_lat", k, MEM_LAT + 2);
    endtask

    task automatic dl_start(input logic [7:0] ix);
        int k;
        @(negedge clk_sys);
        ioctl_index = ix; ioctl_download = 1'b1;
`ifdef PC8001M_LOAD_CSUM_EN
        csum_m = '0;
`endif
        if (ix[5:0] == 6'(LOAD_INDEX)) begin
            k = 0;
            while (!ioctl_wait && k < 50) begin @(negedge clk_sys); k++; end
            chk("dl_drain_wait", ioctl_wait, 1);
            k = 0;
            while (ioctl_wait && k < 50) begin @(negedge clk_sys); k++; end
            chk("dl_load_wait", ioctl_wait, 0);
        end
    endtask

    // One strobe every two clocks.
    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input logic match);
        wr_t w;
        @(negedge clk_sys);
        if (ioctl_wait) wait_seen = 1'b1;
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
        if (match && a < (25'd1 << ROM_AW)) begin
            w.a = a[ROM_AW-1:0]; w.d = d;
            wq.push_back(w);
            shadow[a[ROM_AW-1:0]] = d;
`ifdef PC8001M_LOAD_CSUM_EN
            csum_m = csum_m + {8'h00, d};
`endif
        end
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic dl_end(input logic match);
        int n;
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        if (match) begin
            @(negedge clk_sys);
`ifdef PC8001M_LOAD_CSUM_EN
            chk("csum_release", load_csum, csum_m);
`endif
            n = 0;
            while (cpu_rst_hold && n < 500) begin n++; @(negedge clk_sys); end
            chk("release_len", n, HOLD_CYC);
        end
        chk("idle_busy", load_busy, 0);
        chk("idle_hold", cpu_rst_hold, 0);
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, we0;
        ack_t e;

        // 1. reset values and release hold length
        repeat (2) @(negedge clk_sys);
        chk("rst_hold", cpu_rst_hold, 1);
        chk("rst_busy", load_busy, 1);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_ack", cpu_ack, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_ovf", load_ovf, 0);
        reset = 1'b0;
        n = 0;
        while (cpu_rst_hold && n < 200) begin n++; @(negedge clk_sys); end
        chk("boot_hold_len", n, HOLD_CYC);
        chk("boot_busy", load_busy, 0);

        // 2. full 256-byte download, data == addr
        we0 = we_cnt;
        dl_start(8'd1);
        wait_seen = 1'b0;
        for (int i = 0; i < 256; i++) send_byte(25'(i), 8'(i), 1'b1);
        chk("stream_wait_low", wait_seen, 0);
        dl_end(1'b1);
        chk("stream_we_cnt", we_cnt - we0, 256);
        chk("stream_ovf", load_ovf, 0);
        cpu_op(1'b0, 15'h0000, 8'h00);
        cpu_op(1'b0, 15'h00A7, 8'h00);
        cpu_op(1'b0, 15'h00FF, 8'h00);

        // 3. out-of-range byte dropped, ovf sticky
        we0 = we_cnt;
        dl_start(8'd1);
        send_byte(25'h8000, 8'hA5, 1'b1);
        send_byte(25'h0300, 8'h5A, 1'b1);
        dl_end(1'b1);
        chk("ovf_we_cnt", we_cnt - we0, 1);
        chk("ovf_set", load_ovf, 1);
        repeat (5) @(negedge clk_sys);
        chk("ovf_sticky", load_ovf, 1);

        // 4. read in flight when the download starts; also 0xFF x4 sum
        @(negedge clk_sys);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
        e.rd = 1'b1; e.d = shadow[15'h0010];
        aq.push_back(e);
        @(negedge clk_sys);
        ioctl_index = 8'd1; ioctl_download = 1'b1;
`ifdef PC8001M_LOAD_CSUM_EN
        csum_m = '0;
`endif
        k = 1;
        while (!cpu_ack && k < 50) begin @(negedge clk_sys); k++; end
        cpu_req = 1'b0;
        chk("inflight_ack_lat", k, MEM_LAT + 2);
        chk("inflight_in_drain", ioctl_wait, 1);
        k = 0;
        while (ioctl_wait && k < 50) begin @(negedge clk_sys); k++; end
        chk("inflight_then_load", ioctl_wait, 0);
        chk("ovf_cleared", load_ovf, 0);
        for (int i = 0; i < 4; i++) send_byte(25'h0200 + 25'(i), 8'hFF, 1'b1);
`ifdef PC8001M_LOAD_CSUM_EN
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        chk("csum_ff4", load_csum, 16'h03FC);
        n = 0;
        while (cpu_rst_hold && n < 500) begin n++; @(negedge clk_sys); end
        chk("release_len_ff", n, HOLD_CYC);
`else
        dl_end(1'b1);
`endif

        // 5. non-matching index: CPU keeps the port, no ROM writes
        we0 = we_cnt;
        dl_start(8'd2);
        chk("nomatch_wait", ioctl_wait, 0);
        send_byte(25'h0050, 8'h77, 1'b0);
        cpu_op(1'b1, 15'h0400, 8'h3C);
        cpu_op(1'b0, 15'h0400, 8'h00);
        cpu_op(1'b0, 15'h0050, 8'h00);
        chk("nomatch_hold", cpu_rst_hold, 0);
        chk("nomatch_we_cnt", we_cnt - we0, 1);
        dl_end(1'b0);

        // 6. async reset in the middle of a load
        dl_start(8'd1);
        send_byte(25'h8001, 8'h11, 1'b1);
        send_byte(25'h0600, 8'h22, 1'b1);
        repeat (2) @(negedge clk_sys);
        chk("midload_ovf", load_ovf, 1);
        reset = 1'b1;
        #1;
        chk("midrst_hold", cpu_rst_hold, 1);
        chk("midrst_busy", load_busy, 1);
        chk("midrst_wait", ioctl_wait, 0);
        chk("midrst_ovf", load_ovf, 0);
        chk("midrst_mem_we", mem_we, 0);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        n = 0;
        while (load_busy && n < 200) begin n++; @(negedge clk_sys); end
        chk("midrst_idle", load_busy, 0);
        cpu_op(1'b0, 15'h0600, 8'h00);

        repeat (4) @(negedge clk_sys);
        chk("wq_drained", wq.size(), 0);
        chk("aq_drained", aq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
